midi_tx_encoder: RTL and testbench
==================================

MIDI_TX_ENCODER -- requirements
Module: midi_tx_encoder

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 31250, MIDI line rate in bit/s.
REQ-003 Parameter RUNNING_STATUS, default 1, 1 = omit a repeated channel status byte.
REQ-004 Port CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset_reg_N  input  1  reset, asynchronous assert, active-low.
REQ-006 Port msg_valid  input  1  message offered.
REQ-007 Port msg_ready  output  1  block can accept a message.
REQ-008 Port msg_status  input  8  MIDI status byte.
REQ-009 Port msg_data1  input  8  first data byte; bit 7 ignored.
REQ-010 Port msg_data2  input  8  second data byte; bit 7 ignored.
REQ-011 Port midi_txd  output  1  serial MIDI out, 8N1, idle high.
REQ-012 Port busy  output  1  high while a frame is on the line.
REQ-013 Port byte_done  output  1  one-cycle pulse at the end of each stop bit.
REQ-014 Port msg_err  output  1  one-cycle pulse when a message with msg_status < 0x80 is accepted.

Function
REQ-015 BIT_CLKS = CLK_HZ/BAUD (integer, 1600 at defaults); every line bit lasts exactly BIT_CLKS cycles.
REQ-016 Frame format: start bit 0, 8 data bits LSB first, stop bit 1; 10*BIT_CLKS cycles per byte; consecutive bytes of one message have no idle gap.
REQ-017 States: IDLE, START, DATA, STOP; msg_ready = 1 only in IDLE.
REQ-018 A message is accepted on a rising edge with msg_valid & msg_ready; all three input bytes are captured on that edge; the inputs are don't-care afterwards.
REQ-019 Latency: midi_txd falls (start bit) on the first edge after acceptance; msg_ready deasserts on that same edge.
REQ-020 Length rule: 0x80-0xBF, 0xE0-0xEF, 0xF2 send 3 bytes; 0xC0-0xDF, 0xF1, 0xF3 send 2 bytes; 0xF0, 0xF4-0xFF send 1 byte.
REQ-021 Running status: a register holds the last channel status (0x80-0xEF) sent; if RUNNING_STATUS=1 and msg_status equals it, the status byte is skipped and only the data bytes are sent.
REQ-022 0xF0-0xF7 clears the running-status register; 0xF8-0xFF leaves it unchanged; a channel status always updates it.
REQ-023 Data bytes are transmitted with bit 7 forced to 0.
REQ-024 msg_status < 0x80: the message is accepted, nothing is transmitted, msg_err pulses on the acceptance edge+1, msg_ready stays high with no gap, running status is unchanged.
REQ-025 After the final stop bit of a message, the FSM returns to IDLE and msg_ready rises on the same edge that byte_done pulses.
REQ-026 A back-to-back message accepted on the first IDLE cycle starts its start bit on the next edge (1 idle-high cycle between messages).
REQ-027 busy = 1 from the start-bit edge through the last stop-bit cycle; busy = 0 in IDLE.
REQ-028 The bit counter and bit-timer wrap only via explicit reload; no partial bit is ever emitted except under reset.

Reset
REQ-029 While reset_reg_N = 0: midi_txd = 1, msg_ready = 0, busy = 0, byte_done = 0, msg_err = 0, FSM = IDLE, running status cleared, timers = 0.
REQ-030 Reset asserted mid-frame truncates the frame immediately (midi_txd = 1 asynchronously); the captured message is discarded.
REQ-031 msg_ready rises on the first rising edge after reset_reg_N deasserts.

Verification
REQ-032 Note-on 0x90,0x3C,0x64 after reset -> 3 frames, bytes 0x90,0x3C,0x64, 48000 cycles total, 3 byte_done pulses, msg_ready high at cycle 48000 after the start-bit edge.
REQ-033 A second 0x90,0x40,0x7F with RUNNING_STATUS=1 -> only 0x40,0x7F are sent (32000 cycles); with RUNNING_STATUS=0 -> all 3 bytes are sent.
REQ-034 0x90,0x3C,0x64, then 0xF8, then 0x90,0x3E,0x50 -> 0xF8 is sent as 1 byte; the third message omits its status byte. Replacing 0xF8 with 0xF6 -> the third message resends 0x90.
REQ-035 Program change 0xC5,0x8A,0x11 -> 2 bytes 0xC5,0x0A are sent; data2 is ignored; bit 7 of data1 is cleared.
REQ-036 Status 0x45 -> no line activity, msg_err is a single pulse, msg_ready never drops.
REQ-037 Assert reset_reg_N = 0 during the 5th data bit of a frame -> midi_txd = 1 at once; after release, msg_ready = 1 next edge; the next 0x90 message sends its status byte (running status cleared).

Source files
------------

// File: rtl/midi_tx_encoder.sv
// midi_tx_encoder: MIDI 8N1 transmitter that frames 1-3 byte messages and applies running status.
module midi_tx_encoder #(
  parameter int CLK_HZ         = 50000000,
  parameter int BAUD           = 31250,
  parameter int RUNNING_STATUS = 1
) (
  input  logic       CLOCK_50,
  input  logic       reset_reg_N,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic [7:0] msg_status,
  input  logic [7:0] msg_data1,
  input  logic [7:0] msg_data2,
  output logic       midi_txd,
  output logic       busy,
  output logic       byte_done,
  output logic       msg_err
);
  localparam int BIT_CLKS = CLK_HZ / BAUD;
  localparam int TW = $clog2(BIT_CLKS + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nx;
  logic [TW-1:0] tmr;
  logic [2:0] bit_idx;
  logic [1:0] left, len;
  logic [23:0] sbuf;
  logic [7:0] rs, d1, d2;
  logic live, accept, bit_end, chan, skip, stop_end;
  assign accept = msg_valid & msg_ready;
  assign bit_end = tmr == TW'(BIT_CLKS - 1);
  assign stop_end = state == STOP && bit_end;
  assign d1 = msg_data1 & 8'h7F;
  assign d2 = msg_data2 & 8'h7F;
  assign chan = msg_status >= 8'h80 && msg_status < 8'hF0;
  assign skip = RUNNING_STATUS != 0 && chan && msg_status == rs;
  // len = 0 marks a malformed (data-range) status byte
  always_comb
    len = msg_status < 8'h80 ? 2'd0 :
          (msg_status < 8'hC0 || chan && msg_status >= 8'hE0 || msg_status == 8'hF2) ? 2'd3 :
          (msg_status < 8'hE0 || msg_status == 8'hF1 || msg_status == 8'hF3) ? 2'd2 : 2'd1;
  always_ff @(posedge CLOCK_50 or negedge reset_reg_N)
    if (!reset_reg_N) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept && len != 2'd0 ? START : IDLE;
      START:   state_nx = bit_end ? DATA : START;
      DATA:    state_nx = bit_end && bit_idx == 3'd7 ? STOP : DATA;
      default: state_nx = bit_end ? (left == 2'd1 ? IDLE : START) : STOP;
    endcase
  end
  always_comb begin
    msg_ready = live && state == IDLE;
    busy = state != IDLE;
    midi_txd = state == START ? 1'b0 : state == DATA ? sbuf[bit_idx] : 1'b1;
  end
  always_ff @(posedge CLOCK_50 or negedge reset_reg_N)
    if (!reset_reg_N) begin
      tmr <= '0;
      bit_idx <= '0;
      left <= '0;
      sbuf <= '0;
      rs <= '0;
      live <= 1'b0;
      byte_done <= 1'b0;
      msg_err <= 1'b0;
    end else begin
      live <= 1'b1;
      byte_done <= stop_end;
      msg_err <= accept && len == 2'd0;
      tmr <= (state == IDLE || bit_end) ? '0 : tmr + TW'(1);
      bit_idx <= (state != DATA || bit_end && bit_idx == 3'd7) ? '0 : bit_idx + {2'b0, bit_end};
      if (accept && len != 2'd0) begin
        sbuf <= skip ? {8'h00, d2, d1} : {d2, d1, msg_status};
        left <= skip ? len - 2'd1 : len;
      end else if (stop_end) begin
        sbuf <= {8'h00, sbuf[23:8]};
        left <= left - 2'd1;
      end
      // system real-time (F8-FF) leaves running status untouched
      if (accept && msg_status >= 8'h80 && msg_status < 8'hF8) rs <= chan ? msg_status : 8'h00;
    end
endmodule

// File: tb/tb_midi_tx_encoder.sv
// tb_midi_tx_encoder: directed scoreboard bench; dut1 uses running status, dut0 does not.
module tb_midi_tx_encoder;
  localparam int B = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] valid = 2'b00;
  logic [7:0] st = 8'h00, d1 = 8'h00, d2 = 8'h00;
  logic [1:0] rdy, txd, busy, bd, err;
  int total = 0, bad = 0;
  logic [8:0] sbq[$];
  logic [1:0][7:0] rsm = '0;
  int pos[2] = '{-1, -1};
  logic [1:0][9:0] fr;

  always #5 clk = ~clk;

  midi_tx_encoder #(.CLK_HZ(B * 10000), .BAUD(10000), .RUNNING_STATUS(0)) dut0 (
    .CLOCK_50(clk), .reset_reg_N(rst_n), .msg_valid(valid[0]), .msg_ready(rdy[0]),
    .msg_status(st), .msg_data1(d1), .msg_data2(d2), .midi_txd(txd[0]),
    .busy(busy[0]), .byte_done(bd[0]), .msg_err(err[0]));
  midi_tx_encoder #(.CLK_HZ(B * 10000), .BAUD(10000), .RUNNING_STATUS(1)) dut1 (
    .CLOCK_50(clk), .reset_reg_N(rst_n), .msg_valid(valid[1]), .msg_ready(rdy[1]),
    .msg_status(st), .msg_data1(d1), .msg_data2(d2), .midi_txd(txd[1]),
    .busy(busy[1]), .byte_done(bd[1]), .msg_err(err[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: pushes the bytes the line must carry for the current inputs.
  task automatic model(input int k, output int nb);
    int len;
    len = (st inside {[8'h80:8'hBF], [8'hE0:8'hEF], 8'hF2}) ? 3 :
          (st inside {[8'hC0:8'hDF], 8'hF1, 8'hF3}) ? 2 : (st >= 8'hF0) ? 1 : 0;
    nb = 0;
    if (len == 0) return;
    if (!(k == 1 && st < 8'hF0 && st == rsm[k])) begin sbq.push_back({k[0], st}); nb++; end
    if (len > 1) begin sbq.push_back({k[0], 1'b0, d1[6:0]}); nb++; end
    if (len > 2) begin sbq.push_back({k[0], 1'b0, d2[6:0]}); nb++; end
    if (st < 8'hF0) rsm[k] = st;
    else if (st < 8'hF8) rsm[k] = 8'h00;
  endtask

  task automatic accept(input int k, output int nb);
    chk("ready_pre", rdy[k], 1);
    chk("txd_idle_pre", txd[k], 1);
    model(k, nb);
    valid[k] = 1'b1;
    @(posedge clk); #1;
    valid[k] = 1'b0;
    st = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
    if (nb > 0) begin
      chk("txd_start", txd[k], 0);
      chk("ready_drop", rdy[k], 0);
      chk("busy_start", busy[k], 1);
    end
  endtask

  task automatic finish(input int k, input int nb);
    int n = 0, nbd = 0, errs;
    bit ok = 1'b1;
    if (nb == 0) begin
      errs = err[k];
      ok = rdy[k] & txd[k];
      repeat (3) begin
        @(posedge clk); #1;
        errs += err[k];
        ok &= rdy[k] & txd[k] & ~busy[k];
      end
      chk("err_pulses", errs, 1);
      chk("err_ready_kept", ok, 1);
    end else begin
      do begin
        @(posedge clk); #1;
        n++;
        nbd += bd[k];
        if (!rdy[k] && busy[k] !== 1'b1) ok = 1'b0;
      end while (!rdy[k] && n < 40 * B);
      chk("msg_cycles", n, nb * 10 * B);
      chk("byte_done_count", nbd, nb);
      chk("byte_done_at_ready", bd[k], 1);
      chk("busy_during_msg", ok, 1);
      chk("busy_idle", busy[k], 0);
      chk("queue_drained", sbq.size(), 0);
    end
  endtask

  task automatic send(input int k, input logic [7:0] s, input logic [7:0] a, input logic [7:0] b);
    int nb;
    st = s; d1 = a; d2 = b;
    accept(k, nb);
    finish(k, nb);
  endtask

  // Line monitor: samples mid-bit on the falling clock edge and pops the scoreboard per frame.
  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) pos[k] = -1;
      else begin
        if (pos[k] >= 0) pos[k]++;
        else if (txd[k] === 1'b0) pos[k] = 0;
        if (pos[k] >= 0 && pos[k] % B == B / 2) begin
          fr[k][pos[k] / B] = txd[k];
          if (pos[k] / B == 9) begin
            chk("frame_bits", {fr[k][9], fr[k][0]}, 2'b10);
            chk("frame_byte", {k[0], fr[k][8:1]}, sbq.size() != 0 ? sbq.pop_front() : 9'bx);
            pos[k] = -1;
          end
        end
      end
    end

  initial begin
    int nb;
    #2;
    chk("rst_txd", txd, 2'b11);
    chk("rst_ready", rdy, 2'b00);
    chk("rst_busy", busy, 2'b00);
    chk("rst_byte_done", bd, 2'b00);
    chk("rst_err", err, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", rdy, 2'b00);
    @(posedge clk); #1;
    chk("ready_after_release", rdy, 2'b11);
    send(1, 8'h90, 8'h3C, 8'h64);
    send(1, 8'h90, 8'h40, 8'h7F);
    send(1, 8'hF8, 8'h00, 8'h00);
    send(1, 8'h90, 8'h3E, 8'h50);
    send(1, 8'hF6, 8'h00, 8'h00);
    send(1, 8'h90, 8'h3E, 8'h50);
    send(1, 8'hC5, 8'h8A, 8'h11);
    send(1, 8'h45, 8'h12, 8'h34);
    send(1, 8'hC5, 8'h05, 8'h00);
    send(1, 8'hF2, 8'hFF, 8'h81);
    send(1, 8'hF3, 8'h83, 8'h00);
    send(0, 8'h90, 8'h3C, 8'h64);
    send(0, 8'h90, 8'h40, 8'h7F);
    send(1, 8'h90, 8'h11, 8'h22);
    st = 8'h90; d1 = 8'h2C; d2 = 8'h00;
    accept(1, nb);
    repeat (5 * B + B / 2) @(posedge clk);
    #3 chk("txd_data_bit4", txd[1], 0);
    rst_n = 1'b0;
    #1;
    chk("txd_async_reset", txd[1], 1);
    chk("busy_async_reset", busy[1], 0);
    chk("ready_async_reset", rdy[1], 0);
    sbq.delete();
    rsm = '0;
    repeat (3) @(posedge clk);
    #1 chk("ready_held_in_reset", rdy, 2'b00);
    chk("byte_done_in_reset", bd, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_midframe_reset", rdy[1], 1);
    send(1, 8'h90, 8'h3C, 8'h64);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
